// File: rtl/piso_serializer.sv
// piso_serializer - parallel-in/serial-out transmitter feeding the sipo deserializer.
// Accepts a WIDTH-bit word on a valid/ready handshake and emits one bit per clock.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH - 1);
    localparam logic [3:0]     GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam bit             NO_GAP   = (GAP == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [3:0]       gcnt, gcnt_next;
    logic             rdy_en;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] shreg_shifted;

    // Holds in_ready low until the first clock edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
            gcnt  <= '0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            cnt   <= cnt_next;
            gcnt  <= gcnt_next;
        end
    end

    assign last_bit = (state == ST_SHIFT) && (cnt == '0);

    // Ready is a function of state and counter only, never of in_valid.
    assign in_ready = rdy_en && ((state == ST_IDLE) || (last_bit && NO_GAP));
    assign accept   = in_valid && in_ready;

    assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg[WIDTH-1:1]};

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        gcnt_next  = gcnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    shreg_next = in_data;
                    cnt_next   = CNT_MAX;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_next = shreg_shifted;
                cnt_next   = cnt - CW'(1);
                if (cnt == '0) begin
                    if (NO_GAP) begin
                        // A word accepted on the last bit reloads with no bubble.
                        if (accept) begin
                            shreg_next = in_data;
                            cnt_next   = CNT_MAX;
                            state_next = ST_SHIFT;
                        end else begin
                            cnt_next   = '0;
                            state_next = ST_IDLE;
                        end
                    end else begin
                        cnt_next   = '0;
                        gcnt_next  = GAP_LOAD;
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gcnt == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    gcnt_next = gcnt - 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                shreg_next = '0;
                cnt_next   = '0;
                gcnt_next  = '0;
            end
        endcase
    end

    // Serial outputs decode registered state only, so reset clears them at once.
    assign sout_valid  = (state == ST_SHIFT);
    assign sout        = sout_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign frame_start = sout_valid && (cnt == CNT_MAX);
    assign done        = last_bit;

endmodule
